// File: rtl/sync_tx_pkg.sv
// Shared types and defaults for the 1101-sync serial link (transmitter and detector bench).
package sync_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int         SYNC_PRE_LEN  = 4;
    localparam logic [3:0] SYNC_PREAMBLE = 4'b1101;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left-on-enable register; the MSB is the serial output.
module piso_shreg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  shift,
    output logic                  serial
);

    logic [DATA_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign serial = sr[DATA_WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle gap bits,
// one line bit per bit_en strobe.
module sync_frame_tx
    import sync_tx_pkg::*;
#(
    parameter int                 DATA_WIDTH = 8,
    parameter int                 PRE_LEN    = SYNC_PRE_LEN,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = SYNC_PREAMBLE,
    parameter int                 GAP_LEN    = 1,
    parameter logic               IDLE_BIT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_MAX = max3(PRE_LEN, DATA_WIDTH, GAP_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PRE_LEN-1:0] pre_sr;
    logic               ser;
    logic               accept;
    logic               pre_last;
    logic               data_last;
    logic               gap_last;
    logic               shift;

    assign accept    = (state == IDLE) && tx_valid;
    assign pre_last  = (bit_cnt == CNT_W'(PRE_LEN - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign gap_last  = (bit_cnt == CNT_W'(GAP_LEN - 1));

    // The payload MSB is put on the line at the PRE->DATA edge, so the register
    // shifts on that edge and on every DATA bit except the last.
    assign shift = bit_en && (((state == PRE) && pre_last) ||
                              ((state == DATA) && !data_last));

    piso_shreg #(.DATA_WIDTH(DATA_WIDTH)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .din    (tx_data),
        .shift  (shift),
        .serial (ser)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            pre_sr     <= '0;
            serial_out <= IDLE_BIT;
            frame_done <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Accept edge ignores bit_en: first preamble bit goes out right away.
                    if (tx_valid) begin
                        state      <= PRE;
                        bit_cnt    <= '0;
                        pre_sr     <= PREAMBLE << 1;
                        serial_out <= PREAMBLE[PRE_LEN-1];
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                PRE: begin
                    if (bit_en) begin
                        if (pre_last) begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            serial_out <= ser;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            serial_out <= pre_sr[PRE_LEN-1];
                            pre_sr     <= pre_sr << 1;
                        end
                    end
                end
                DATA: begin
                    if (bit_en) begin
                        if (data_last) begin
                            state      <= GAP;
                            bit_cnt    <= '0;
                            serial_out <= IDLE_BIT;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            serial_out <= ser;
                        end
                    end
                end
                GAP: begin
                    if (bit_en) begin
                        serial_out <= IDLE_BIT;
                        if (gap_last) begin
                            state      <= IDLE;
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                            tx_ready   <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx with a behavioural Mealy 1101 detector on the line.
module tb_sync_frame_tx;
    import sync_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int idx;
    int det_cnt;
    int det_idx;
    logic [1:0] det_st;
    logic       det_pulse;

    always #5 clk = ~clk;

    sync_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Overlapping Mealy 1101 detector, output combinational on the line.
    assign det_pulse = (det_st == 2'd3) && serial_out;
    always @(posedge clk) begin
        if (rst) det_st <= 2'd0;
        else case (det_st)
            2'd0: det_st <= serial_out ? 2'd1 : 2'd0;
            2'd1: det_st <= serial_out ? 2'd2 : 2'd0;
            2'd2: det_st <= serial_out ? 2'd2 : 2'd3;
            default: det_st <= serial_out ? 2'd1 : 2'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (bit %0d, t=%0t): got %0h want %0h", tag, idx, $time, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. nv/nd drive tx_valid/tx_data while busy.
    // abort_at >= 0 asserts rst at the negedge showing that frame bit index.
    task automatic send_frame(input logic [7:0] d, input int per, input logic nv,
                              input logic [7:0] nd, input int abort_at);
        logic [12:0] exp_v;
        int ph;
        int cyc;
        exp_v = {4'b1101, d, 1'b0};
        ph = 0;
        cyc = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        bit_en   = 1'b0;
        @(negedge clk);
        tx_valid = nv;
        tx_data  = nd;
        idx = 0;
        while (idx < 13 && cyc < 200) begin
            chk("line", serial_out, exp_v[12-idx]);
            chk("busy", busy, 1);
            chk("done_early", frame_done, 0);
            chk("ready_busy", tx_ready, 0);
            if (det_pulse) begin
                det_cnt++;
                det_idx = idx;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                bit_en = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                tx_valid = 1'b0;
                bit_en = 1'b0;
                chk("abort_line", serial_out, 0);
                chk("abort_ready", tx_ready, 1);
                chk("abort_busy", busy, 0);
                for (int k = 0; k < 16; k++) begin
                    chk("abort_done", frame_done, 0);
                    chk("abort_idle_line", serial_out, 0);
                    @(negedge clk);
                end
                chk("abort_ready_after", tx_ready, 1);
                return;
            end
            bit_en = (ph == per - 1);
            ph = (ph + 1) % per;
            @(negedge clk);
            cyc++;
            if (bit_en) idx++;
        end
        bit_en = 1'b0;
        chk("frame_len", cyc, 13 * per);
        chk("frame_done", frame_done, 1);
        chk("ready_end", tx_ready, 1);
        chk("busy_end", busy, 0);
        chk("line_end", serial_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        bit_en = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        det_cnt = 0;
        det_idx = -1;
        idx = 0;

        // Reset held two cycles with tx_valid high: nothing accepted.
        @(negedge clk);
        chk("rst_line", serial_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        @(negedge clk);
        chk("rst_busy2", busy, 0);
        rst = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy3", busy, 0);
        chk("rst_line2", serial_out, 0);

        // Single frame, full rate.
        send_frame(8'hA5, 1, 1'b0, 8'h00, -1);
        @(negedge clk);
        chk("done_pulse_width", frame_done, 0);

        // Bit strobe every third cycle.
        send_frame(8'h3C, 3, 1'b0, 8'h00, -1);
        @(negedge clk);

        // Back-to-back: tx_valid held through the first frame with the second word.
        send_frame(8'hFF, 1, 1'b1, 8'h00, -1);
        send_frame(8'h00, 1, 1'b0, 8'h00, -1);
        @(negedge clk);

        // Busy-time request ignored, then abort at DATA bit 4.
        send_frame(8'h96, 1, 1'b1, 8'hFF, 8);

        // Loopback into the detector: one pulse, on the 4th preamble bit.
        det_cnt = 0;
        det_idx = -1;
        send_frame(8'h00, 1, 1'b0, 8'h00, -1);
        for (int k = 0; k < 4; k++) begin
            if (det_pulse) det_cnt++;
            @(negedge clk);
        end
        chk("det_count", det_cnt, 1);
        chk("det_align", det_idx, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
